// File: rtl/pipe_stage.sv
// Handshaked pipeline register with flush, zero-bubble payload and sticky sideband.
// Define PIPE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module pipe_stage #(
  parameter int DATA_W = 160,
  parameter int SIDE_W = 65,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SIDE_W-1:0] out_side,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SIDE_W-1:0] side_q, side_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_xfer;
  logic              out_xfer;

`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [SIDE_W-1:0] skid_side_q, skid_side_d;

  assign in_ready = (state_q != SKID) & ~rst;
`else
  assign in_ready = ((state_q == EMPTY) | out_ready) & ~rst;
`endif

  assign out_valid    = (state_q != EMPTY);
  assign out_data     = data_q;
  assign out_side     = side_q;
  assign occupancy    = state_q;
  assign stall_cycles = cnt_q;
  assign in_xfer      = in_valid & in_ready;
  assign out_xfer     = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    side_d  = side_q;
`ifdef PIPE_SKID_EN
    skid_data_d = skid_data_q;
    skid_side_d = skid_side_q;
`endif
    if (flush) begin
      // accepted beat is dropped; sideband stays sticky
      state_d = EMPTY;
      data_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = FULL;
            data_d  = in_data;
            side_d  = in_side;
          end
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            data_d = in_data;
            side_d = in_side;
          end else if (in_xfer) begin
`ifdef PIPE_SKID_EN
            state_d     = SKID;
            skid_data_d = in_data;
            skid_side_d = in_side;
`endif
          end else if (out_xfer) begin
            state_d = EMPTY;
            data_d  = '0;
          end
        end
        SKID: begin
`ifdef PIPE_SKID_EN
          if (out_xfer) begin
            state_d = FULL;
            data_d  = skid_data_q;
            side_d  = skid_side_q;
          end
`endif
        end
        default: begin
          state_d = EMPTY;
          data_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && !(&cnt_q))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      side_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      side_q  <= side_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPE_SKID_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_data_q <= '0;
      skid_side_q <= '0;
    end else begin
      skid_data_q <= skid_data_d;
      skid_side_q <= skid_side_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: queue-based reference model plus directed scenarios.
// Works with or without PIPE_SKID_EN defined.
module tb_pipe_stage;
  localparam int DW = 160;
  localparam int SW = 65;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [SW-1:0] in_side = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_side;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cycles;

  int cmp_n = 0;
  int err_n = 0;

  pipe_stage #(.DATA_W(DW), .SIDE_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_side(in_side),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_side(out_side),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] got,
                     input logic [255:0] exp);
    cmp_n++;
    if (got !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } beat_t;

  beat_t         mq[$];
  logic [SW-1:0] m_side = '0;
  int            m_cnt = 0;
  bit            m_live = 0;

  function automatic logic m_in_ready();
`ifdef PIPE_SKID_EN
    return !rst && (mq.size() < 2);
`else
    return !rst && (mq.size() == 0 || out_ready);
`endif
  endfunction

  // reference model: held beats as a FIFO, front beat is what is presented
  initial forever begin
    bit ix, ox;
    @(posedge clk);
    ix = in_valid && m_in_ready();
    ox = (mq.size() > 0) && out_ready;
    if (rst) begin
      mq.delete();
      m_side = '0;
      m_cnt  = 0;
    end else begin
      if (mq.size() > 0 && !out_ready && m_cnt < CMAX) m_cnt++;
      if (flush) mq.delete();
      else begin
        if (ox) void'(mq.pop_front());
        if (ix) mq.push_back('{d: in_data, s: in_side});
      end
      if (mq.size() > 0) m_side = mq[0].s;
    end
    m_live = 1;
  end

  initial forever begin
    logic [DW-1:0] ed;
    @(negedge clk);
    if (m_live) begin
      ed = (mq.size() > 0) ? mq[0].d : '0;
      chk("m_out_valid", out_valid, mq.size() > 0);
      chk("m_out_data", out_data, ed);
      chk("m_out_side", out_side, m_side);
      chk("m_occupancy", occupancy, mq.size());
      chk("m_stall", stall_cycles, m_cnt);
      chk("m_in_ready", in_ready, m_in_ready());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [SW-1:0] rnd_side();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[SW-1:0];
  endfunction

  initial begin
    logic [DW-1:0] bp_beats[3];
    logic [DW-1:0] got[$];
    int sent;
    bit acc;

    rst = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    // streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      in_side  = SW'(i);
      tick();
      chk("stream_data", out_data, i);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_bubble", out_valid, 0);

    // fill, then reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(32'hA1);
    in_side   = SW'(32'h5A);
    tick();
    in_data = DW'(32'hB2);
    tick();
`ifdef PIPE_SKID_EN
    chk("fill_occ", occupancy, 2);
`else
    chk("fill_occ", occupancy, 1);
`endif
    chk("fill_in_ready", in_ready, 0);
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_side", out_side, 0);
    chk("midrst_occ", occupancy, 0);
    chk("midrst_stall", stall_cycles, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);

    // backpressure: A, B, C with out_ready low for five edges
    bp_beats[0] = DW'(32'hA);
    bp_beats[1] = DW'(32'hB);
    bp_beats[2] = DW'(32'hC);
    sent = 0;
    got.delete();
    for (int k = 0; k < 40 && got.size() < 3; k++) begin
      if (k == 3) chk("bp_in_ready", in_ready, 0);
      if (k == 5) chk("bp_stall", stall_cycles, 4);
      in_valid  = (sent < 3);
      in_data   = bp_beats[sent < 3 ? sent : 2];
      in_side   = SW'(sent);
      out_ready = (k >= 5);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) got.push_back(out_data);
      tick();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    if (got.size() < 3) begin
      err_n++;
      $display("FAIL bp_timeout: got %0d beats expected 3", got.size());
    end else begin
      chk("bp_order0", got[0], 32'hA);
      chk("bp_order1", got[1], 32'hB);
      chk("bp_order2", got[2], 32'hC);
    end
    repeat (3) tick();

    // sticky sideband through bubbles
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = DW'(32'h55);
    in_side   = 65'h1_0000_1234;
    tick();
    in_valid = 1'b0;
    in_side  = rnd_side();
    repeat (3) tick();
    chk("sticky_valid", out_valid, 0);
    chk("sticky_data", out_data, 0);
    chk("sticky_side", out_side, 65'h1_0000_1234);

    // flush with concurrent input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(32'h77);
    in_side   = SW'(32'h99);
    tick();
    flush   = 1'b1;
    in_data = DW'(32'hAA);
    in_side = SW'(32'hBB);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_occ", occupancy, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_side", out_side, 32'h99);
    repeat (3) tick();
    chk("flush_no_aa", out_data, 0);

    // counter saturation
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(1);
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("sat_stall", stall_cycles, 15);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_after_flush", stall_cycles, 15);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = (n % 600 < 300) ? (($urandom % 3) != 0)
                                  : (($urandom % 3) == 0);
      flush     = ($urandom % 32) == 0;
      rst       = ($urandom % 256) == 0;
      in_data   = rnd_data();
      in_side   = rnd_side();
      tick();
    end
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
